// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the pipeline hazard controller and any
//   future unit that compares register sources against a producer (for
//   example a forwarding unit).
//   Contents:
//     hz_state_e : controller FSM states {IDLE, LU_STALL, MEM_WAIT}
//     REG_X0     : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // x0 always reads zero, so a write to it never creates a dependency.
  localparam int REG_X0 = 0;

endpackage

// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if
//   Bundles the pipeline-side signals of the hazard controller.
//   Modports:
//     master : the pipeline (drives the stage info, consumes the controls)
//     slave  : hazard_ctrl_unit
//   Signals (direction as seen by the slave):
//     id_ex_memread_i, id_ex_rd_i   in   EX instruction is a load / its rd
//     if_id_rs1_i, if_id_rs2_i      in   ID instruction sources
//     use_rs1_i, use_rs2_i          in   ID instruction actually reads rsN
//     branch_taken_i                in   branch resolved taken in ID
//     mem_req_i, mem_ack_i          in   MEM stage access / completion
//     pc_write_o, stall_o, noop_o   out  PC enable, IF/ID hold, ID/EX bubble
//     flush_o, mem_stall_o          out  IF/ID squash, EX/MEM+MEM/WB freeze
//     stall_cnt_o                   out  saturating count of stall cycles
// ---------------------------------------------------------------------------
interface hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              id_ex_memread_i;
  logic [REG_AW-1:0] id_ex_rd_i;
  logic [REG_AW-1:0] if_id_rs1_i;
  logic [REG_AW-1:0] if_id_rs2_i;
  logic              use_rs1_i;
  logic              use_rs2_i;
  logic              branch_taken_i;
  logic              mem_req_i;
  logic              mem_ack_i;
  logic              pc_write_o;
  logic              stall_o;
  logic              noop_o;
  logic              flush_o;
  logic              mem_stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_ex_memread_i, id_ex_rd_i, if_id_rs1_i, if_id_rs2_i,
           use_rs1_i, use_rs2_i, branch_taken_i, mem_req_i, mem_ack_i,
    input  pc_write_o, stall_o, noop_o, flush_o, mem_stall_o, stall_cnt_o
  );

  modport slave (
    input  id_ex_memread_i, id_ex_rd_i, if_id_rs1_i, if_id_rs2_i,
           use_rs1_i, use_rs2_i, branch_taken_i, mem_req_i, mem_ack_i,
    output pc_write_o, stall_o, noop_o, flush_o, mem_stall_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_src_match.sv
// ---------------------------------------------------------------------------
// hazard_src_match
//   Combinational producer/consumer register match. Flags when a valid
//   producer writes a non-x0 register that the consumer actually reads
//   through rs1 or rs2.
//   Ports:
//     load_i              in   producer is valid (a load, for load-use)
//     rd_i                in   producer destination register
//     rs1_i, rs2_i        in   consumer source registers
//     use_rs1_i/use_rs2_i in   consumer really reads that source
//     hit_o               out  dependency detected
// ---------------------------------------------------------------------------
module hazard_src_match #(
  parameter int REG_AW = 5
) (
  input  logic              load_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  output logic              hit_o
);
  import hazard_pkg::*;

  logic rd_live;
  logic rs1_match;
  logic rs2_match;

  assign rd_live   = load_i && (rd_i != REG_AW'(REG_X0));
  // An encoding field that happens to equal rd is not a dependency unless
  // the instruction really consumes that source.
  assign rs1_match = use_rs1_i && (rd_i == rs1_i);
  assign rs2_match = use_rs2_i && (rd_i == rs2_i);
  assign hit_o     = rd_live && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//   Pipeline hazard controller sitting beside the ID stage of the 5-stage
//   core. Inserts LU_CYC bubbles per load-use hazard, freezes the whole
//   pipeline while a data-memory access waits for its ack, gates the ID
//   branch flush and counts stalled cycles (saturating).
//   Outputs are combinational from registered state and current inputs, so
//   a load-use hazard stalls in the very cycle it is seen.
//   Parameters: REG_AW register address width, LU_CYC bubbles per load-use
//   hazard (>=1), CNT_W stall counter width.
//   Ports:
//     clk_i  in  clock
//     rst_i  in  asynchronous reset, active-high
//     bus    hazard_if.slave (stage info in, pipeline controls out)
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int LU_CYC = 1,
  parameter int CNT_W  = 16
) (
  input  logic     clk_i,
  input  logic     rst_i,
  hazard_if.slave  bus
);
  import hazard_pkg::*;

  localparam int              LCW       = $clog2(LU_CYC + 1);
  localparam logic [LCW-1:0]  LU_RELOAD = LCW'(LU_CYC - 1);

  hz_state_e        state_q, state_d;
  hz_state_e        eff_state;
  logic [LCW-1:0]   lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_hit;
  logic mem_busy;
  logic stall;
  logic noop;
  logic mem_stall;

  hazard_src_match #(
    .REG_AW (REG_AW)
  ) u_src_match (
    .load_i    (bus.id_ex_memread_i),
    .rd_i      (bus.id_ex_rd_i),
    .rs1_i     (bus.if_id_rs1_i),
    .rs2_i     (bus.if_id_rs2_i),
    .use_rs1_i (bus.use_rs1_i),
    .use_rs2_i (bus.use_rs2_i),
    .hit_o     (lu_hit)
  );

  assign mem_busy = bus.mem_req_i && !bus.mem_ack_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    stall     = 1'b0;
    noop      = 1'b0;
    mem_stall = 1'b0;

    // Leaving MEM_WAIT behaves as if already in the state we return to,
    // so a load-use sequence interrupted by a memory wait resumes with
    // the bubbles it still owed.
    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = (lu_cnt_q != '0) ? LU_STALL : IDLE;
    end

    if (mem_busy) begin
      // Whole pipeline frozen; no bubble since ID/EX must hold as well.
      mem_stall = 1'b1;
      stall     = 1'b1;
      state_d   = MEM_WAIT;
    end else begin
      unique case (eff_state)
        LU_STALL: begin
          stall    = 1'b1;
          noop     = 1'b1;
          lu_cnt_d = lu_cnt_q - LCW'(1);
          state_d  = (lu_cnt_q == LCW'(1)) ? IDLE : LU_STALL;
        end
        default: begin
          state_d = IDLE;
          if (lu_hit) begin
            stall = 1'b1;
            noop  = 1'b1;
            if (LU_CYC > 1) begin
              lu_cnt_d = LU_RELOAD;
              state_d  = LU_STALL;
            end
          end
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.noop_o      = noop;
  assign bus.mem_stall_o = mem_stall;
  assign bus.pc_write_o  = !stall;
  // A taken branch whose operands are still unresolved must not squash.
  assign bus.flush_o     = bus.branch_taken_i && !stall;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  // flags vector layout: {pc_write, stall, noop, flush, mem_stall}
  typedef struct {
    int          k;
    logic [4:0]  f;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mr, u1, u2, bt, req, ack;
  logic [4:0] rd, rs1, rs2;

  int    total = 0;
  int    bad   = 0;
  string tag   = "init";
  exp_t  sb[$];

  // Reference model: bubbles still owed and the stall count, per instance.
  int luc [3] = '{1, 3, 2};
  int cmax[3] = '{65535, 65535, 3};
  int m_left[3];
  int m_sc  [3];

  hazard_if #(.REG_AW(5), .CNT_W(16)) if_a ();
  hazard_if #(.REG_AW(5), .CNT_W(16)) if_b ();
  hazard_if #(.REG_AW(5), .CNT_W(2))  if_c ();

  hazard_ctrl_unit #(.REG_AW(5), .LU_CYC(1), .CNT_W(16)) u_a (
    .clk_i (clk), .rst_i (rst), .bus (if_a));
  hazard_ctrl_unit #(.REG_AW(5), .LU_CYC(3), .CNT_W(16)) u_b (
    .clk_i (clk), .rst_i (rst), .bus (if_b));
  hazard_ctrl_unit #(.REG_AW(5), .LU_CYC(2), .CNT_W(2)) u_c (
    .clk_i (clk), .rst_i (rst), .bus (if_c));

  task automatic drive_all();
    if_a.id_ex_memread_i = mr;  if_b.id_ex_memread_i = mr;  if_c.id_ex_memread_i = mr;
    if_a.id_ex_rd_i      = rd;  if_b.id_ex_rd_i      = rd;  if_c.id_ex_rd_i      = rd;
    if_a.if_id_rs1_i     = rs1; if_b.if_id_rs1_i     = rs1; if_c.if_id_rs1_i     = rs1;
    if_a.if_id_rs2_i     = rs2; if_b.if_id_rs2_i     = rs2; if_c.if_id_rs2_i     = rs2;
    if_a.use_rs1_i       = u1;  if_b.use_rs1_i       = u1;  if_c.use_rs1_i       = u1;
    if_a.use_rs2_i       = u2;  if_b.use_rs2_i       = u2;  if_c.use_rs2_i       = u2;
    if_a.branch_taken_i  = bt;  if_b.branch_taken_i  = bt;  if_c.branch_taken_i  = bt;
    if_a.mem_req_i       = req; if_b.mem_req_i       = req; if_c.mem_req_i       = req;
    if_a.mem_ack_i       = ack; if_b.mem_ack_i       = ack; if_c.mem_ack_i       = ack;
  endtask

  task automatic clear_inputs();
    mr = 0; u1 = 0; u2 = 0; bt = 0; req = 0; ack = 0;
    rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic set_hit();
    mr = 1; rd = 5'd5; rs1 = 5'd5; u1 = 1;
  endtask

  task automatic sample(input int k, output logic [4:0] f, output logic [15:0] c);
    case (k)
      0: begin
        f = {if_a.pc_write_o, if_a.stall_o, if_a.noop_o, if_a.flush_o, if_a.mem_stall_o};
        c = if_a.stall_cnt_o;
      end
      1: begin
        f = {if_b.pc_write_o, if_b.stall_o, if_b.noop_o, if_b.flush_o, if_b.mem_stall_o};
        c = if_b.stall_cnt_o;
      end
      default: begin
        f = {if_c.pc_write_o, if_c.stall_cnt_o == 2'd0 ? if_c.stall_o : if_c.stall_o,
             if_c.noop_o, if_c.flush_o, if_c.mem_stall_o};
        c = 16'(if_c.stall_cnt_o);
      end
    endcase
  endtask

  // One cycle: drive at negedge, predict, sample 1 time unit later,
  // then advance the model to the state the coming posedge produces.
  task automatic step(input logic r);
    int   nl[3];
    int   ns[3];
    exp_t e;
    logic hit, busy;
    logic [4:0]  f;
    logic [15:0] c;
    @(negedge clk);
    rst = r;
    drive_all();
    hit  = mr && (rd != 0) && ((rd == rs1 && u1) || (rd == rs2 && u2));
    busy = req && !ack;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_left[k] = 0;
        m_sc[k]   = 0;
      end
      nl[k] = m_left[k];
      if (busy)              e.f = 5'b01001;
      else if (m_left[k] > 0) begin e.f = 5'b01100; nl[k] = m_left[k] - 1; end
      else if (hit)          begin e.f = 5'b01100; nl[k] = luc[k] - 1; end
      else                   e.f = 5'b10000;
      if (bt && !e.f[3]) e.f[1] = 1'b1;
      ns[k] = (e.f[3] && m_sc[k] < cmax[k]) ? m_sc[k] + 1 : m_sc[k];
      e.k = k;
      e.c = 16'(m_sc[k]);
      sb.push_back(e);
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.k, f, c);
      total++;
      if (f !== e.f || c !== e.c) begin
        bad++;
        $display("FAIL sb_%s inst=%0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tag, e.k, f, c, e.f, e.c);
      end
    end
    if (!r) begin
      for (int k = 0; k < 3; k++) begin
        m_left[k] = nl[k];
        m_sc[k]   = ns[k];
      end
    end
  endtask

  task automatic pulse_reset();
    clear_inputs();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic test_reset();
    logic [4:0] f; logic [15:0] c;
    tag = "reset";
    clear_inputs();
    step(1'b1);
    for (int k = 0; k < 3; k++) begin
      sample(k, f, c);
      total++;
      if (f !== 5'b10000 || c !== 16'd0) begin
        bad++;
        $display("FAIL reset inst=%0d got flags=%b cnt=%0d want flags=10000 cnt=0", k, f, c);
      end
    end
    step(1'b0);
  endtask

  task automatic test_load_use();
    tag = "load_use";
    pulse_reset();
    set_hit();
    step(1'b0);
    total++;
    if (if_a.stall_o !== 1'b1 || if_a.noop_o !== 1'b1 || if_a.pc_write_o !== 1'b0) begin
      bad++;
      $display("FAIL load_use_stall got stall=%b noop=%b pcw=%b want 1 1 0",
               if_a.stall_o, if_a.noop_o, if_a.pc_write_o);
    end
    clear_inputs();
    step(1'b0);
    total++;
    if (if_a.stall_o !== 1'b0 || if_a.stall_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL load_use_release got stall=%b cnt=%0d want stall=0 cnt=1",
               if_a.stall_o, if_a.stall_cnt_o);
    end
    repeat (3) step(1'b0);
  endtask

  task automatic test_x0_and_use();
    logic [4:0] f; logic [15:0] c;
    tag = "x0_use";
    pulse_reset();
    mr = 1; rd = 0; rs1 = 0; u1 = 1;
    step(1'b0);
    for (int k = 0; k < 3; k++) begin
      sample(k, f, c);
      total++;
      if (f[3] !== 1'b0) begin
        bad++;
        $display("FAIL x0_no_stall inst=%0d got stall=%b want 0", k, f[3]);
      end
    end
    rd = 5'd7; rs2 = 5'd7; u2 = 0; rs1 = 5'd3; u1 = 1;
    step(1'b0);
    for (int k = 0; k < 3; k++) begin
      sample(k, f, c);
      total++;
      if (f[3] !== 1'b0) begin
        bad++;
        $display("FAIL unused_rs2 inst=%0d got stall=%b want 0", k, f[3]);
      end
    end
    clear_inputs();
    step(1'b0);
  endtask

  task automatic test_multi_cycle();
    logic [5:0] pat;
    tag = "multi";
    pulse_reset();
    set_hit();
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      pat[5-i] = if_b.stall_o;
      clear_inputs();
    end
    step(1'b0);
    total++;
    if (pat !== 6'b111000 || if_b.stall_cnt_o !== 16'd3) begin
      bad++;
      $display("FAIL multi_cycle got pattern=%b cnt=%0d want pattern=111000 cnt=3",
               pat, if_b.stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    tag = "mem_wait";
    pulse_reset();
    req = 1; ack = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      total++;
      if ({if_a.mem_stall_o, if_a.stall_o, if_a.noop_o, if_a.pc_write_o} !== 4'b1100) begin
        bad++;
        $display("FAIL mem_wait_%0d got ms/st/noop/pcw=%b%b%b%b want 1100", i,
                 if_a.mem_stall_o, if_a.stall_o, if_a.noop_o, if_a.pc_write_o);
      end
    end
    ack = 1;
    step(1'b0);
    total++;
    if ({if_a.mem_stall_o, if_a.stall_o, if_a.pc_write_o} !== 3'b001) begin
      bad++;
      $display("FAIL mem_ack got ms/st/pcw=%b%b%b want 001",
               if_a.mem_stall_o, if_a.stall_o, if_a.pc_write_o);
    end
    clear_inputs();
    step(1'b0);
  endtask

  task automatic test_branch_flush();
    tag = "flush";
    pulse_reset();
    set_hit();
    bt = 1;
    step(1'b0);
    total++;
    if (if_a.flush_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_masked got flush=%b want 0", if_a.flush_o);
    end
    clear_inputs();
    bt = 1;
    step(1'b0);
    total++;
    if (if_a.flush_o !== 1'b1 || if_a.pc_write_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_after got flush=%b pcw=%b want 1 1", if_a.flush_o, if_a.pc_write_o);
    end
    clear_inputs();
    repeat (3) step(1'b0);
  endtask

  task automatic test_reset_mid_stall();
    tag = "rst_mid";
    pulse_reset();
    set_hit();
    step(1'b0);
    clear_inputs();
    step(1'b0);
    step(1'b1);
    total++;
    if ({if_b.pc_write_o, if_b.stall_o, if_b.noop_o, if_b.flush_o, if_b.mem_stall_o} !== 5'b10000
        || if_b.stall_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_stall got stall=%b cnt=%0d want stall=0 cnt=0",
               if_b.stall_o, if_b.stall_cnt_o);
    end
    step(1'b0);
    total++;
    if (if_b.stall_o !== 1'b0 || if_b.noop_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_residual got stall=%b noop=%b want 0 0", if_b.stall_o, if_b.noop_o);
    end
  endtask

  task automatic test_saturation();
    tag = "sat";
    pulse_reset();
    set_hit();
    repeat (6) step(1'b0);
    clear_inputs();
    step(1'b0);
    total++;
    if (if_c.stall_cnt_o !== 2'd3 || if_a.stall_cnt_o !== 16'd6) begin
      bad++;
      $display("FAIL saturation got narrow=%0d wide=%0d want narrow=3 wide=6",
               if_c.stall_cnt_o, if_a.stall_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    tag = "b2b";
    pulse_reset();
    set_hit();
    step(1'b0);
    clear_inputs();
    req = 1;
    repeat (2) step(1'b0);
    req = 0;
    step(1'b0);
    total++;
    if (if_b.noop_o !== 1'b1 || if_b.mem_stall_o !== 1'b0 || if_a.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL resume_bubble got b.noop=%b b.ms=%b a.stall=%b want 1 0 0",
               if_b.noop_o, if_b.mem_stall_o, if_a.stall_o);
    end
    repeat (3) step(1'b0);
  endtask

  task automatic test_random();
    tag = "rand";
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      mr  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      bt  = 1'($urandom_range(0, 1));
      req = ($urandom_range(0, 3) == 0);
      ack = 1'($urandom_range(0, 1));
      step(1'b0);
    end
    clear_inputs();
    step(1'b0);
  endtask

  initial begin
    clear_inputs();
    drive_all();
    test_reset();
    test_load_use();
    test_x0_and_use();
    test_multi_cycle();
    test_mem_wait();
    test_branch_flush();
    test_reset_mid_stall();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
